// File: rtl/stack_arb_pkg.sv
// Shared types for the two-requester stack arbiter.
// FSM state encodings and requester index constants.
package stack_arb_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        WAIT = ST_WAIT,
        RESP = ST_RESP
    } state_e;

    localparam int unsigned REQ0 = 0;
    localparam int unsigned REQ1 = 1;

endpackage

// File: rtl/rr_arb2.sv
// Combinational two-way round-robin pick.
// gnt is the index of the chosen requester; last is the previous grant.
module rr_arb2
    import stack_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic       gnt
);

    always_comb begin
        gnt = 1'b0;
        if (req == 2'b11) begin
            gnt = ~last;
        end else if (req[REQ1]) begin
            gnt = 1'b1;
        end
    end

endmodule

// File: rtl/stack_arbiter.sv
// Arbitrates two requesters onto one stack port (IDLE/WAIT/RESP).
// Define STACK_ARB_DEPTHCHK_EN to reject pops when empty / pushes when full.
module stack_arbiter
    import stack_arb_pkg::*;
#(
    parameter int DATA  = 32,
    parameter int DEPTH = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [1:0]                   req,
    input  logic [1:0]                   push_req,
    input  logic [DATA-1:0]              wdata0,
    input  logic [DATA-1:0]              wdata1,
    output logic [1:0]                   ack,
    output logic [1:0]                   err,
    output logic [DATA-1:0]              rdata,
    output logic                         stk_push,
    output logic                         stk_trigger,
    output logic [DATA-1:0]              stk_write,
    input  logic [DATA-1:0]              stk_read,
    input  logic                         stk_done,
    output logic [$clog2(DEPTH+1)-1:0]   depth
);

    localparam int DW = $clog2(DEPTH + 1);
    localparam logic [DW-1:0] DMAX = DW'(DEPTH);

    state_e          state_q, state_d;
    logic            last_q, last_d;
    logic [1:0]      ack_q, ack_d;
    logic [DATA-1:0] rdata_q, rdata_d;
    logic            push_q, push_d;
    logic            trig_q, trig_d;
    logic [DATA-1:0] wr_q, wr_d;
    logic [DW-1:0]   depth_q, depth_d;
    logic            pick;
    logic            rej;

`ifdef STACK_ARB_DEPTHCHK_EN
    logic [1:0]      err_q, err_d;
`endif

    rr_arb2 u_rr (
        .req  (req),
        .last (last_q),
        .gnt  (pick)
    );

`ifdef STACK_ARB_DEPTHCHK_EN
    always_comb begin
        rej = push_req[pick] ? (depth_q == DMAX)
                             : (depth_q == '0);
    end
`else
    assign rej = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        ack_d   = '0;
        rdata_d = rdata_q;
        push_d  = push_q;
        trig_d  = 1'b0;
        wr_d    = wr_q;
        depth_d = depth_q;
`ifdef STACK_ARB_DEPTHCHK_EN
        err_d   = '0;
`endif
        unique case (state_q)
            IDLE: begin
                if (|req) begin
                    last_d = pick;
                    if (rej) begin
                        // rejected op answers directly without touching the stack
                        ack_d[pick] = 1'b1;
`ifdef STACK_ARB_DEPTHCHK_EN
                        err_d[pick] = 1'b1;
`endif
                        state_d = RESP;
                    end else begin
                        trig_d  = 1'b1;
                        push_d  = push_req[pick];
                        wr_d    = pick ? wdata1 : wdata0;
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (stk_done) begin
                    ack_d[last_q] = 1'b1;
                    state_d       = RESP;
                    if (push_q) begin
                        if (depth_q != DMAX) depth_d = depth_q + 1'b1;
                    end else begin
                        rdata_d = stk_read;
                        if (depth_q != '0) depth_d = depth_q - 1'b1;
                    end
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            ack_q   <= '0;
            rdata_q <= '0;
            push_q  <= 1'b0;
            trig_q  <= 1'b0;
            wr_q    <= '0;
            depth_q <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            ack_q   <= ack_d;
            rdata_q <= rdata_d;
            push_q  <= push_d;
            trig_q  <= trig_d;
            wr_q    <= wr_d;
            depth_q <= depth_d;
        end
    end

`ifdef STACK_ARB_DEPTHCHK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= '0;
        end else begin
            err_q <= err_d;
        end
    end
    assign err = err_q;
`else
    assign err = '0;
`endif

    assign ack         = ack_q;
    assign rdata       = rdata_q;
    assign stk_push    = push_q;
    assign stk_trigger = trig_q;
    assign stk_write   = wr_q;
    assign depth       = depth_q;

endmodule

// File: doc/stack_arbiter.md
STACK_ARBITER -- requirements
Module: stack_arbiter

Interface
REQ-001 Parameter DATA, default 32, sets the stack word width in bits.
REQ-002 Parameter DEPTH, default 8, sets the stack capacity in words.
REQ-003 Port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-004 Port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 Port req, input, 2 bits: per-requester operation request, held until that requester's ack.
REQ-006 Port push_req, input, 2 bits: per-requester operation type, 1=push, 0=pop; stable while req high.
REQ-007 Ports wdata0 and wdata1, input, DATA bits each: push data for requesters 0 and 1; stable while req high.
REQ-008 Port ack, output, 2 bits: one-hot, one-cycle completion pulse to the granted requester.
REQ-009 Port err, output, 2 bits: qualifies ack; 1 means the operation was rejected.
REQ-010 Port rdata, output, DATA bits: popped word; valid while the matching ack is high.
REQ-011 Port stk_push, output, 1 bit: operation type driven to the stack.
REQ-012 Port stk_trigger, output, 1 bit: one-cycle start pulse to the stack.
REQ-013 Port stk_write, output, DATA bits: push data driven to the stack.
REQ-014 Port stk_read, input, DATA bits: stack pop result.
REQ-015 Port stk_done, input, 1 bit: single-cycle stack completion pulse.
REQ-016 Port depth, output, $clog2(DEPTH+1) bits: current stack occupancy.

Function
REQ-017 The FSM SHALL have states IDLE, WAIT and RESP.
REQ-018 In IDLE with any req bit high, the block SHALL select a grant, register stk_trigger=1, stk_push and stk_write from the granted requester, and go to WAIT.
REQ-019 stk_trigger SHALL be high for exactly one cycle per issued operation.
REQ-020 In WAIT, the block SHALL hold stk_push and stk_write and ignore req; on stk_done it SHALL register rdata=stk_read (pops only), set ack for the grant, and go to RESP.
REQ-021 RESP SHALL last one cycle, with ack and err valid and req ignored; the next state SHALL be IDLE.
REQ-022 Latency: for req sampled in IDLE at cycle N, trigger SHALL be high at N+1 and ack high one cycle after the stk_done cycle.
REQ-023 Arbitration SHALL be round-robin: if both req bits are high, grant the requester not granted last; a single request is always granted.
REQ-024 The requester SHALL drop req on the edge at which ack is seen; the block SHALL issue no second operation from the same request.
REQ-025 If req drops during WAIT, the operation SHALL still complete and ack SHALL still pulse.
REQ-026 depth SHALL increment on completed push and decrement on completed pop, never wrapping.
REQ-027 err SHALL be 0 on every accepted operation; rdata SHALL keep its previous value after a push.

Reset
REQ-028 On rst_n low: state=IDLE; ack=0, err=0, rdata=0, stk_push=0, stk_trigger=0, stk_write=0, depth=0; round-robin pointer favours requester 0.
REQ-029 Reset asserted mid-operation SHALL abandon the operation without an ack; a later stk_done arriving in IDLE SHALL be ignored.

Configuration
REQ-030 Macro STACK_ARB_DEPTHCHK_EN defined: a pop at depth=0 or a push at depth=DEPTH SHALL skip the stack and go straight from IDLE to RESP with ack and err set; depth is unchanged; the round-robin pointer still advances.
REQ-031 Macro undefined: no rejection is performed, err SHALL be tied to 0, and depth SHALL still track occupancy, saturating at 0 and DEPTH.

Structure
REQ-032 Package stack_arb_pkg SHALL hold the FSM state enum (IDLE, WAIT, RESP) and the requester index constants REQ0=0 and REQ1=1.
REQ-033 Sub-module rr_arb2 SHALL implement the combinational two-way round-robin pick from req and the last-grant pointer; all sequencing stays in stack_arbiter.

Verification
REQ-034 Requester 0 pushes 0x0000_002A; the stack model returns done two cycles after trigger -> trigger is high one cycle, ack=01 three cycles after trigger, depth=1, err=0.
REQ-035 After two pushes, requester 1 pops with stk_read=0x0000_0007 -> ack=10, rdata=0x0000_0007, depth=1.
REQ-036 Both req bits held high from reset for four operations -> grant order 0,1,0,1 and exactly four trigger pulses.
REQ-037 With STACK_ARB_DEPTHCHK_EN defined, a pop at depth=0 -> no trigger, ack=01 and err=01 on the second cycle, depth=0; with the macro undefined the same pop issues a trigger.
REQ-038 Assert rst_n low while in WAIT, then release it and pulse stk_done -> no ack, all outputs at reset values, next req served normally.
REQ-039 Requester 0 drops req one cycle after trigger -> the operation completes and ack=01 still pulses once.
